// File: rtl/act_requant_absmax.sv
// act_requant_absmax: buffers one vector of signed accumulator sums and tracks
// its absolute maximum. It then re-emits every element as a saturated signed
// OUT_W-bit activation, scaled down by a power of two chosen from that maximum.
// The applied right-shift is reported on out_shift so later stages can undo it.
module act_requant_absmax #(
    parameter int unsigned VECTOR_LEN = 4096,
    parameter int unsigned IN_W       = 20,
    parameter int unsigned OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [4:0]       out_shift
);

    localparam int unsigned CW = $clog2(VECTOR_LEN + 1);
    localparam int unsigned AW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam int unsigned LW = $clog2(IN_W + 1);

    // Symmetric output range: the most negative code is never produced.
    localparam logic signed [IN_W:0] QMAX = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] QMIN = -QMAX;

    typedef enum logic [1:0] {
        COLLECT,
        SHIFT,
        EMIT
    } state_e;

    state_e state_q, state_d;

    logic [IN_W-1:0]  mem [VECTOR_LEN];

    logic [CW-1:0]    count_q, count_d;
    logic [IN_W-1:0]  absmax_q, absmax_d;
    logic [CW-1:0]    rd_q, rd_d;
    logic [4:0]       shift_q, shift_d;
    logic             ov_q, ov_d;
    logic [OUT_W-1:0] od_q, od_d;
    logic             ol_q, ol_d;

    logic             in_fire;
    logic             out_fire;
    logic             last_in;
    logic             emit_active;
    logic             load;
    logic [IN_W-1:0]  in_abs;
    logic [LW-1:0]    bitlen;
    logic [4:0]       shift_calc;
    logic [IN_W-1:0]  rd_word;
    logic [IN_W-1:0]  rnd;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    logic [OUT_W-1:0] q_val;

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign out_shift = shift_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = ov_q && out_ready;
    // A full buffer ends the vector even without in_last.
    assign last_in  = in_last || (count_q == CW'(VECTOR_LEN - 1));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (in_fire && last_in) state_d = SHIFT;
            SHIFT:   state_d = EMIT;
            EMIT:    if (out_fire && ol_q) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: accept input only while collecting and out of reset
    always_comb begin
        in_ready    = (state_q == COLLECT) && !rst;
        emit_active = (state_q == EMIT);
    end

    // Vector buffer write; contents need no reset since count gates all reads
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[count_q[AW-1:0]] <= in_data;
        end
    end

    // Magnitude of the incoming sample in IN_W unsigned bits
    always_comb begin
        in_abs = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
    end

    // Bit length of absmax and the resulting right-shift
    always_comb begin
        bitlen = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (absmax_q[i]) bitlen = LW'(i + 1);
        end
        shift_calc = '0;
        if (bitlen > LW'(OUT_W - 1)) begin
            shift_calc = 5'(bitlen - LW'(OUT_W - 1));
        end
    end

    // Requantise the element at the read index: round half up, shift, saturate
    always_comb begin
        rd_word = mem[rd_q[AW-1:0]];
        rnd     = '0;
        if (shift_q != 5'd0) begin
            rnd = IN_W'(1) << (shift_q - 5'd1);
        end
        sum     = $signed({rd_word[IN_W-1], rd_word}) + $signed({1'b0, rnd});
        shifted = sum >>> shift_q;
        if (shifted > QMAX) begin
            q_val = QMAX[OUT_W-1:0];
        end else if (shifted < QMIN) begin
            q_val = QMIN[OUT_W-1:0];
        end else begin
            q_val = shifted[OUT_W-1:0];
        end
    end

    // Datapath next-state: count/absmax, shift capture, output register refill
    always_comb begin
        count_d  = count_q;
        absmax_d = absmax_q;
        rd_d     = rd_q;
        shift_d  = shift_q;
        ov_d     = ov_q;
        od_d     = od_q;
        ol_d     = ol_q;

        if (in_fire) begin
            count_d = count_q + CW'(1);
            if (in_abs > absmax_q) absmax_d = in_abs;
        end

        if (state_q == SHIFT) begin
            shift_d = shift_calc;
            rd_d    = '0;
        end

        // One-entry output register that refills on the same cycle it drains,
        // so a continuously ready sink sees one element per clock.
        load = emit_active && (rd_q < count_q) && (!ov_q || out_ready);
        if (load) begin
            ov_d = 1'b1;
            od_d = q_val;
            ol_d = (rd_q == count_q - CW'(1));
            rd_d = rd_q + CW'(1);
        end else if (out_fire) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end

        if (out_fire && ol_q) begin
            count_d  = '0;
            absmax_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            absmax_q <= '0;
            rd_q     <= '0;
            shift_q  <= '0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            ol_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            absmax_q <= absmax_d;
            rd_q     <= rd_d;
            shift_q  <= shift_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            ol_q     <= ol_d;
        end
    end

endmodule

// File: tb/tb_act_requant_absmax.sv
// Directed bench for act_requant_absmax with an 8-deep buffer.
module tb_act_requant_absmax;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [4:0]  out_shift;

    int total = 0;
    int bad   = 0;

    act_requant_absmax #(
        .VECTOR_LEN(8),
        .IN_W(20),
        .OUT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_shift(out_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] vals;
        logic [7:0][31:0] exp;
        logic [31:0]      len;
        logic             has_last;
        logic [31:0]      shift;
        logic [31:0]      pat;
    } vec_t;

    vec_t tv [8];

    function automatic logic [7:0][31:0] pk8(input int a0 = 0, input int a1 = 0,
                                             input int a2 = 0, input int a3 = 0,
                                             input int a4 = 0, input int a5 = 0,
                                             input int a6 = 0, input int a7 = 0);
        logic [7:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Push one vector, then drain it with the vector's out_ready pattern.
    task automatic run_vec(input int t);
        int len;
        int w;
        int edges;
        int idx;
        int k;
        int cyc;
        len = int'(tv[t].len);
        for (int e = 0; e < len; e++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tv[t].vals[e][19:0];
            in_last  = tv[t].has_last && (e == len - 1);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("in_ready_after_last", int'(in_ready), 0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("first_valid_latency", edges, 2);

        idx = 0;
        k   = 0;
        cyc = 0;
        while (idx < len && cyc < 200) begin
            out_ready = (tv[t].pat == 0) ? 1'b1 : ((k % 3) == 0);
            k++;
            if (out_valid) begin
                chk($sformatf("v%0d_data%0d", t, idx), int'($signed(out_data)),
                    int'($signed(tv[t].exp[idx])));
                chk($sformatf("v%0d_last%0d", t, idx), int'(out_last),
                    (idx == len - 1) ? 1 : 0);
                chk($sformatf("v%0d_shift", t), int'(out_shift), int'(tv[t].shift));
                if (out_ready) idx++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (idx < len) chk("emit_timeout", idx, len);
        out_ready = 1'b0;
        chk("in_ready_after_emit", int'(in_ready), 1);
        chk("out_valid_after_emit", int'(out_valid), 0);
        chk("shift_held", int'(out_shift), int'(tv[t].shift));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        tv[0] = '{vals: pk8(100, -50, 3, 0, 127, -127, 1, 2),
                  exp:  pk8(100, -50, 3, 0, 127, -127, 1, 2),
                  len: 8, has_last: 1'b1, shift: 0, pat: 0};
        tv[1] = '{vals: pk8(1000, -1000, 500, 3), exp: pk8(125, -125, 63, 0),
                  len: 4, has_last: 1'b1, shift: 3, pat: 0};
        tv[2] = '{vals: pk8(255, -255, -254), exp: pk8(127, -127, -127),
                  len: 3, has_last: 1'b1, shift: 1, pat: 0};
        tv[3] = '{vals: pk8(-524288, 0), exp: pk8(-64, 0),
                  len: 2, has_last: 1'b1, shift: 13, pat: 0};
        tv[4] = '{vals: pk8(0, 0, 0), exp: pk8(0, 0, 0),
                  len: 3, has_last: 1'b1, shift: 0, pat: 0};
        tv[5] = '{vals: pk8(10, -20, 30, -40, 50, -60, 70, -80),
                  exp:  pk8(10, -20, 30, -40, 50, -60, 70, -80),
                  len: 8, has_last: 1'b0, shift: 0, pat: 1};
        tv[6] = '{vals: pk8(-300), exp: pk8(-75),
                  len: 1, has_last: 1'b1, shift: 2, pat: 0};
        tv[7] = '{vals: pk8(4, -4), exp: pk8(4, -4),
                  len: 2, has_last: 1'b1, shift: 0, pat: 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_shift", int'(out_shift), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_post_rst", int'(in_ready), 1);

        for (int t = 0; t < 7; t++) begin
            run_vec(t);
        end

        // Reset in the middle of collection discards the partial vector
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 20'(e + 1);
            in_last  = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_shift", int'(out_shift), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("midrst_no_output", int'(out_valid), 0);
            chk("midrst_ready", int'(in_ready), 1);
        end
        run_vec(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
